// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory read-return arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE_A   = 2'd0,
        SEND_S_A = 2'd1,
        SEND_F_A = 2'd2
    } state_t;

    localparam logic SRC_SDRAM = 1'b0;
    localparam logic SRC_FLASH = 1'b1;

    localparam int WAIT_W = 3;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the requester, output and coverage signals around mem_arb.
// Handshake: a transfer happens on a clock edge where valid && ready are both high;
// the sender holds data stable while valid is high and ready is low.
interface mem_arb_if #(parameter int DATA_W = 8);

    logic              sdram_valid;
    logic [DATA_W-1:0] sdram_data_i;
    logic              sdram_ready;
    logic              flash_valid;
    logic [DATA_W-1:0] flash_data_i;
    logic              flash_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready;
    logic [2:0]        coverage;

    modport master (
        output sdram_valid, sdram_data_i, flash_valid, flash_data_i, out_ready,
        input  sdram_ready, flash_ready, out_valid, out_data, out_src, coverage
    );

    modport slave (
        input  sdram_valid, sdram_data_i, flash_valid, flash_data_i, out_ready,
        output sdram_ready, flash_ready, out_valid, out_data, out_src, coverage
    );

endinterface

// File: rtl/mem_arb_hold_buf.sv
// One-entry holding buffer; ready comes from the full flag only, so no input-to-ready path.
module hold_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              ready,
    input  logic              clear,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    // clear only arrives while full, and accept only while empty, so they never collide
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            data <= in_data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

    assign ready = !full;

endmodule

// File: rtl/mem_arb.sv
// SDRAM/flash read-return arbiter: flash normally wins, SDRAM wins once it has lost
// MAX_WAIT flash grants in a row; winner moves into a registered valid/ready output.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 3
) (
    input logic     clock,
    input logic     reset,
    mem_arb_if.slave bus
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic              s_full, f_full;
    logic [DATA_W-1:0] s_data, f_data;
    logic              slot_free, grant, grant_s, grant_f, aged;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_c, out_src_c;
    state_t            state, state_nx;

    hold_buf #(.DATA_W(DATA_W)) u_sdram_buf (
        .clock    (clock),
        .reset    (reset),
        .in_valid (bus.sdram_valid),
        .in_data  (bus.sdram_data_i),
        .ready    (bus.sdram_ready),
        .clear    (grant_s),
        .full     (s_full),
        .data     (s_data)
    );

    hold_buf #(.DATA_W(DATA_W)) u_flash_buf (
        .clock    (clock),
        .reset    (reset),
        .in_valid (bus.flash_valid),
        .in_data  (bus.flash_data_i),
        .ready    (bus.flash_ready),
        .clear    (grant_f),
        .full     (f_full),
        .data     (f_data)
    );

    assign aged      = (wait_cnt == MAX_WAIT_C);
    assign slot_free = !out_valid_c || bus.out_ready;
    assign grant     = slot_free && (s_full || f_full);
    assign grant_s   = grant && s_full && (!f_full || aged);
    assign grant_f   = grant && !grant_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE_A;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (grant_s) begin
            state_nx = SEND_S_A;
        end else if (grant_f) begin
            state_nx = SEND_F_A;
        end else begin
            case (state)
                SEND_S_A, SEND_F_A: if (bus.out_ready) state_nx = IDLE_A;
                default:            state_nx = IDLE_A;
            endcase
        end
    end

    always_comb begin
        out_valid_c = (state == SEND_S_A) || (state == SEND_F_A);
        out_src_c   = (state == SEND_F_A) ? SRC_FLASH : SRC_SDRAM;
    end

    // Counts only flash wins that SDRAM actually contended for
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (grant_s) begin
            wait_cnt <= '0;
        end else if (grant_f && s_full && !aged) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        out_data_q <= '0;
        else if (grant_s) out_data_q <= s_data;
        else if (grant_f) out_data_q <= f_data;
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_src   = out_src_c;
    assign bus.out_data  = out_data_q;
    assign bus.coverage  = {aged, state};

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester arbiter that shares one byte-wide output channel between the SDRAM and flash read-return paths of the memory controller. Each requester has a one-entry holding buffer. A fixed-priority-with-aging scheduler moves buffered bytes into a registered output stage with valid/ready backpressure. The block sits between the memory-controller front ends and the downstream consumer, and exports a small coverage vector for the fuzzing harness.

## Interface
- DATA_W, 8: data width of both requesters and the output.
- MAX_WAIT, 3: flash grants the SDRAM buffer may lose before SDRAM is forced to win; legal range is 1..7.
- clock  in  1  Single clock; all state updates on posedge.
- reset  in  1  Asynchronous, active-high; clears all state immediately.
- sdram_valid  in  1  SDRAM requester offers sdram_data_i.
- sdram_data_i  in  DATA_W  SDRAM byte.
- sdram_ready  out  1  SDRAM holding buffer empty.
- flash_valid  in  1  Flash requester offers flash_data_i.
- flash_data_i  in  DATA_W  Flash byte.
- flash_ready  out  1  Flash holding buffer empty.
- out_valid  out  1  Output register holds a byte.
- out_data  out  DATA_W  Output byte.
- out_src  out  1  Source of out_data: 0 = SDRAM, 1 = flash.
- out_ready  in  1  Consumer accepts the output this cycle.
- coverage  out  3  Concatenation {aged, state[1:0]}.

## Operation
- Holding buffers:
  - Each requester has a buffer of 1 data register plus a full flag.
  - `x_ready = !x_full`. It is driven from state only; there is no combinational path from inputs to ready.
  - An input is accepted when `x_valid && x_ready`. The buffer is full the next cycle.
- Output slot is free when `!out_valid || out_ready`.
- Grant fires when the output slot is free and at least one buffer is full:
  - Only one buffer full: that buffer wins.
  - Both full: SDRAM wins if `wait_cnt == MAX_WAIT` (`aged` = 1); otherwise flash wins.
- On grant, the winner's byte and source load into the output register, and the winner's buffer clears at the same edge.
- wait_cnt (3 bits):
  - +1, saturating at MAX_WAIT, on each flash grant while the SDRAM buffer is full.
  - Cleared on an SDRAM grant.
  - Holds otherwise.
- FSM state[1:0]:
  - IDLE=0: output empty.
  - SEND_S=1: output holds an SDRAM byte.
  - SEND_F=2: output holds a flash byte.
  - Encoding 3 is unreachable; treat it as IDLE.
- FSM transitions:
  - Any state → SEND_S or SEND_F on a grant.
  - SEND_x → IDLE on out_ready with no grant.
  - Otherwise the state holds.
- out_valid = (state != IDLE). out_src = (state == SEND_F).

## Timing
- Reset values: state=IDLE, both buffers empty, wait_cnt=0. Outputs: out_valid=0, out_data=0, out_src=0, sdram_ready=1, flash_ready=1, coverage=0.
- Latency: input accepted at edge N → buffer full after N → earliest grant at edge N+1 → out_valid high in cycle N+1.
- Per-requester throughput is at most 1 byte per 2 cycles, because ready is low during the cycle the buffer is full.
- Output throughput is 1 byte per cycle when out_ready is held high and the buffers alternate.
- While `out_valid && !out_ready`: out_data and out_src are stable, no grant occurs, and full buffers hold (their ready stays low).
- Simultaneous events:
  - out_ready together with a grant: the output reloads at the same edge with no bubble.
  - Input acceptance and grant cannot hit the same buffer in the same edge.
- Reset mid-operation: buffered and output bytes are discarded, and all outputs return to reset values asynchronously. No byte is emitted after reset deasserts until a new input is accepted.

## Structure
- The shared defines file holds:
  - state encodings IDLE_A/SEND_S_A/SEND_F_A;
  - source codes SRC_SDRAM=0 / SRC_FLASH=1.
- Sub-module `hold_buf` (1-entry valid/ready buffer, parameter DATA_W) is instantiated once per requester.
- The grant logic, wait_cnt, FSM and output register stay in mem_arb.

## Test plan
- Reset with both valids high → sdram_ready=flash_ready=1, out_valid=0, coverage=0. After deassert, accept on the first edge.
- SDRAM 0xA5 alone, out_ready=1 → out_valid one cycle after acceptance, out_data=0xA5, out_src=0, then IDLE.
- Both buffers filled in the same cycle (SDRAM 0x11, flash 0x22), out_ready=1 → 0x22/src1, then 0x11/src0 in consecutive cycles.
- Aging with MAX_WAIT=3:
  - Setup: SDRAM 0x33 buffered, flash streaming 0x40,0x41,…; out_ready low except a 1-cycle pulse every 3 cycles.
  - Required: the output sequence is 0x40,0x41,0x42, then 0x33; coverage[2]=1 just before the SDRAM grant, and wait_cnt=0 after it.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles → out_data/out_src constant, flash_ready stays 0 with its buffer full, and no byte is lost or duplicated.
- Reset asserted while in SEND_F with the SDRAM buffer full → out_valid falls immediately, both readys=1, and no stale byte appears after release.
